// File: rtl/csd_coef_mult.sv
// ============================================================================
// csd_coef_mult
// ----------------------------------------------------------------------------
// Purpose:
//   Multiplies each input sample by a per-channel coefficient. Each
//   coefficient is stored in canonical-signed-digit form as NTERMS terms.
//   A term adds or subtracts an arithmetically right-shifted copy of the
//   sample. The terms are summed in a wide accumulator, one term per cycle.
//   The channel's terms are copied into a snapshot when a sample is accepted.
//   Table writes made while a sample is in flight therefore only affect
//   later samples.
//
// Parameters:
//   W       data width (two's complement)
//   NTERMS  CSD terms per coefficient
//   SHW     shift-field width of a term
//   NCH     number of channels; CHW = max(1, clog2(NCH))
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_data, in_ch      input sample and its channel tag
//   out_valid/out_ready output handshake; the result is held until taken
//   out_data, out_ch    product and channel tag of the result
//   cfg_we, cfg_ch,     coefficient table write port
//   cfg_idx, cfg_term   cfg_term = {en, neg, shift}
//   busy                high whenever the FSM is not in IDLE
//
// Configuration macro:
//   CSD_SAT_EN  when defined, out_data saturates to the signed W-bit range.
//               Otherwise out_data is the low W bits of the accumulator.
// ============================================================================
module csd_coef_mult #(
    parameter int W      = 41,
    parameter int NTERMS = 8,
    parameter int SHW    = 6,
    parameter int NCH    = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int IDXW  = (NTERMS > 1) ? $clog2(NTERMS) : 1,
    localparam int TW    = SHW + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [CHW-1:0]   in_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CHW-1:0]   out_ch,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [TW-1:0]    cfg_term,
    output logic             busy
);

    // Accumulator width. The sum of NTERMS terms, each at most |x|, cannot
    // overflow this width.
    localparam int ACCW = W + $clog2(NTERMS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]          coef_tab [NCH][NTERMS];
    logic [TW-1:0]          snap     [NTERMS];
    logic [W-1:0]           data_q;
    logic [CHW-1:0]         ch_q;
    logic [IDXW-1:0]        idx_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_next;
    logic [W-1:0]           out_data_q;
    logic                   last_term;
    logic                   accept;

    // Power-on coefficient: terms 0..4 add x>>>0, x>>>2, x>>>3, x>>>4 and
    // x>>>6 (93/64). All remaining terms are disabled.
    function automatic logic [TW-1:0] default_term(input int t);
        logic [TW-1:0] term;
        term = '0;
        case (t)
            0: term = {2'b10, SHW'(0)};
            1: term = {2'b10, SHW'(2)};
            2: term = {2'b10, SHW'(3)};
            3: term = {2'b10, SHW'(4)};
            4: term = {2'b10, SHW'(6)};
            default: term = '0;
        endcase
        return term;
    endfunction

    // Reduces the wide accumulator to W bits. With saturation, any value
    // whose upper bits are not a pure sign extension is clamped.
    function automatic logic [W-1:0] reduce_acc(input logic signed [ACCW-1:0] a);
`ifdef CSD_SAT_EN
        logic [ACCW-W:0] top;
        top = a[ACCW-1:W-1];
        if ((&top) || (~|top))
            return a[W-1:0];
        else if (a[ACCW-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
`else
        return a[W-1:0];
`endif
    endfunction

    assign accept    = in_valid && (state_q == IDLE);
    assign last_term = (idx_q == IDXW'(NTERMS - 1));

    // Adds the contribution of the current snapshot term to the accumulator.
    // The sample is sign-extended before the shift. The shift therefore
    // rounds toward minus infinity, even for shifts wider than W.
    always_comb begin
        logic signed [ACCW-1:0] x_ext;
        logic signed [ACCW-1:0] shifted;
        logic [TW-1:0]          term;
        x_ext    = $signed({{(ACCW-W){data_q[W-1]}}, data_q});
        term     = snap[idx_q];
        shifted  = x_ext >>> term[SHW-1:0];
        acc_next = acc_q;
        if (term[SHW+1]) begin
            if (term[SHW])
                acc_next = acc_q - shifted;
            else
                acc_next = acc_q + shifted;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic and handshake outputs. ACC always runs the full
    // NTERMS cycles. DONE returns to IDLE only on the output handshake, so
    // a new sample can never be taken in the handshake cycle.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_d = ACC;
            end
            ACC: begin
                if (last_term)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Coefficient table. Writes to a channel or index outside the table are
    // dropped. Reset restores the power-on coefficient in every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTERMS; t++)
                    coef_tab[c][t] <= default_term(t);
        end else if (cfg_we && (32'(cfg_ch) < NCH) && (32'(cfg_idx) < NTERMS)) begin
            coef_tab[cfg_ch][cfg_idx] <= cfg_term;
        end
    end

    // Sample datapath. On accept, the sample, tag and the channel's terms
    // are captured. An unknown channel gets an all-disabled snapshot, so its
    // result is zero. The final sum is registered into out_data on the same
    // edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            for (int t = 0; t < NTERMS; t++)
                snap[t] <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                ch_q   <= in_ch;
                idx_q  <= '0;
                acc_q  <= '0;
                for (int t = 0; t < NTERMS; t++) begin
                    if (32'(in_ch) < NCH)
                        snap[t] <= coef_tab[in_ch][t];
                    else
                        snap[t] <= '0;
                end
            end else if (state_q == ACC) begin
                acc_q <= acc_next;
                idx_q <= idx_q + IDXW'(1);
                if (last_term)
                    out_data_q <= reduce_acc(acc_next);
            end
        end
    end

    assign out_data = out_data_q;
    assign out_ch   = ch_q;

endmodule
